blob_label_resolver: RTL and testbench

- Between-frame controller for the CCL first-pass label-equivalence table.
- On each frame end it walks the exposed equivalence bank through the ll_index/ll_data port and flattens every label to its root.
- Stores the roots in a local root RAM and counts distinct blobs.
- Serves root lookups to the second-pass relabelling stage, arbitrating the root RAM read port between its own resolve walk and the lookup requester.

---
 rtl/blob_pkg.sv | 17 +
 rtl/blob_root_ram.sv | 29 ++
 rtl/blob_label_resolver.sv | 169 ++++++++++++++++
 tb/tb_blob_label_resolver.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// Shared constants and resolver state encoding for the CCL label-equivalence resolver.
package blob_pkg;

  localparam int unsigned LABELSIZE = 8;
  localparam int unsigned INDEXW    = LABELSIZE + 1;

  localparam logic [LABELSIZE-1:0] BG_LABEL = '0;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRead,
    StWrite,
    StDone
  } res_state_e;

endpackage

// File: rtl/blob_root_ram.sv
// Root-label RAM: one write port, one read port with a registered (1-cycle) output.
module blob_root_ram #(
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [Width-1:0] mem [Depth];

  // No reset: contents are only meaningful after a completed resolve walk.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/blob_label_resolver.sv
// Between-frame resolver: flattens the first-pass equivalence table to roots, counts blobs,
// and serves root lookups to the relabelling pass.
module blob_label_resolver
  import blob_pkg::*;
#(
  parameter int unsigned LabelSize = LABELSIZE,
  parameter int unsigned IndexW    = INDEXW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_valid,
  input  logic                 too_many_labels,
  input  logic [LabelSize-1:0] label_count,
  output logic [IndexW-1:0]    ll_index,
  input  logic [LabelSize-1:0] ll_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [LabelSize-1:0] blob_count,
  input  logic                 lookup_req,
  input  logic [LabelSize-1:0] lookup_label,
  output logic                 lookup_ready,
  output logic                 lookup_rvalid,
  output logic [LabelSize-1:0] lookup_root
);

  res_state_e           state_q;
  logic                 fv_q;
  logic [LabelSize-1:0] cnt_q;
  logic [LabelSize-1:0] lbl_q;
  logic                 par_ok_q;
  logic                 hit_q;

  logic                 frame_end;
  logic                 walk_rd;
  logic                 lookup_accept;
  logic                 lookup_hit;
  logic                 ram_we;
  logic                 ram_re;
  logic [LabelSize-1:0] ram_raddr;
  logic [LabelSize-1:0] ram_rdata;
  logic [LabelSize-1:0] root;
  logic [LabelSize-1:0] lbl_nxt;

  always_comb begin
    frame_end     = fv_q & ~frame_valid;
    // Only a strictly smaller, non-background parent already has a resolved root.
    walk_rd       = (state_q == StRead) && (ll_data != LabelSize'(BG_LABEL)) && (ll_data < lbl_q);
    lookup_accept = lookup_req & lookup_ready;
    lookup_hit    = (lookup_label != LabelSize'(BG_LABEL)) && (lookup_label <= cnt_q) &&
                    !overflow;
    ram_re        = walk_rd | lookup_accept;
    ram_raddr     = (state_q == StRead) ? ll_data : lookup_label;
    ram_we        = (state_q == StWrite);
    root          = par_ok_q ? ram_rdata : lbl_q;
    lbl_nxt       = lbl_q + LabelSize'(1);
  end

  assign lookup_root = hit_q ? ram_rdata : '0;

  blob_root_ram #(
    .Width (LabelSize),
    .AddrW (LabelSize)
  ) u_root_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (lbl_q),
    .wdata (root),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      fv_q          <= 1'b0;
      cnt_q         <= '0;
      lbl_q         <= '0;
      par_ok_q      <= 1'b0;
      hit_q         <= 1'b0;
      ll_index      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      blob_count    <= '0;
      lookup_ready  <= 1'b0;
      lookup_rvalid <= 1'b0;
    end else begin
      fv_q          <= frame_valid;
      done          <= 1'b0;
      lookup_rvalid <= lookup_accept;
      hit_q         <= lookup_accept & lookup_hit;

      unique case (state_q)
        StIdle: begin
          if (frame_end) begin
            state_q <= StStart;
          end
        end

        StStart: begin
          cnt_q      <= label_count;
          blob_count <= '0;
          if (too_many_labels) begin
            overflow     <= 1'b1;
            done         <= 1'b1;
            lookup_ready <= 1'b1;
            state_q      <= StDone;
          end else if (label_count == '0) begin
            overflow     <= 1'b0;
            done         <= 1'b1;
            lookup_ready <= 1'b1;
            state_q      <= StDone;
          end else begin
            overflow <= 1'b0;
            lbl_q    <= LabelSize'(1);
            ll_index <= IndexW'(1);
            busy     <= 1'b1;
            state_q  <= StRead;
          end
        end

        StRead: begin
          if (frame_valid) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            par_ok_q <= walk_rd;
            state_q  <= StWrite;
          end
        end

        StWrite: begin
          if (frame_valid) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            if (root == lbl_q) begin
              blob_count <= blob_count + LabelSize'(1);
            end
            if (lbl_q == cnt_q) begin
              busy         <= 1'b0;
              done         <= 1'b1;
              lookup_ready <= 1'b1;
              state_q      <= StDone;
            end else begin
              lbl_q    <= lbl_nxt;
              ll_index <= IndexW'(lbl_nxt);
              state_q  <= StRead;
            end
          end
        end

        StDone: begin
          if (frame_end) begin
            lookup_ready <= 1'b0;
            state_q      <= StStart;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blob_label_resolver.sv
// Randomized bench for blob_label_resolver: plain-loop reference model plus a lookup scoreboard.
module tb_blob_label_resolver;
  import blob_pkg::*;

  localparam int LS = LABELSIZE;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              frame_valid = 1'b0;
  logic              too_many_labels = 1'b0;
  logic [LS-1:0]     label_count = '0;
  logic [INDEXW-1:0] ll_index;
  logic [LS-1:0]     ll_data;
  logic              busy, done, overflow;
  logic [LS-1:0]     blob_count;
  logic              lookup_req = 1'b0;
  logic [LS-1:0]     lookup_label = '0;
  logic              lookup_ready, lookup_rvalid;
  logic [LS-1:0]     lookup_root;

  logic [LS-1:0] tbl [2**INDEXW];
  assign ll_data = tbl[ll_index];

  blob_label_resolver dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .frame_valid     (frame_valid),
    .too_many_labels (too_many_labels),
    .label_count     (label_count),
    .ll_index        (ll_index),
    .ll_data         (ll_data),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow),
    .blob_count      (blob_count),
    .lookup_req      (lookup_req),
    .lookup_label    (lookup_label),
    .lookup_ready    (lookup_ready),
    .lookup_rvalid   (lookup_rvalid),
    .lookup_root     (lookup_root)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    int root;
    int due;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: roots of the last resolved frame.
  int m_root [256];
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ll_index"}, 32'(ll_index), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_blob_count"}, 32'(blob_count), 0);
    check({tag, "_lookup_ready"}, 32'(lookup_ready), 0);
    check({tag, "_lookup_rvalid"}, 32'(lookup_rvalid), 0);
    check({tag, "_lookup_root"}, 32'(lookup_root), 0);
  endtask

  // Each label takes its parent's root if the parent is a smaller real label, else itself.
  function automatic int model_resolve(input int cnt);
    int blobs = 0;
    for (int l = 1; l <= cnt; l++) begin
      int p = int'(tbl[l]);
      int r = (p > 0 && p < l) ? m_root[p] : l;
      m_root[l] = r;
      if (r == l) blobs++;
    end
    return blobs;
  endfunction

  task automatic issue(input int lab);
    exp_t e;
    lookup_req   = 1'b1;
    lookup_label = LS'(lab);
    e.root = (lab >= 1 && lab <= m_cnt && !m_ovf) ? m_root[lab] : 0;
    e.due  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic burst(input int n, input int maxlab);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        lookup_req = 1'b0;
        @(negedge clk);
      end
      issue(int'($urandom_range(0, maxlab)));
    end
    @(negedge clk);
    lookup_req = 1'b0;
  endtask

  task automatic load_random(input int cnt);
    for (int l = 1; l <= cnt; l++) begin
      tbl[l] = ($urandom_range(0, 3) == 0) ? LS'(l) : LS'($urandom_range(0, cnt + 3));
    end
  endtask

  task automatic resolve(input int cnt, input bit ovf, input bit req_at_end, input int req_lab);
    int c0, lat, exp_blob, exp_lat;
    bit seen;
    @(negedge clk);
    frame_valid     = 1'b1;
    label_count     = LS'(cnt);
    too_many_labels = ovf;
    repeat (2) @(negedge clk);
    frame_valid = 1'b0;
    c0 = cyc;
    if (req_at_end) issue(req_lab);
    exp_blob = ovf ? 0 : model_resolve(cnt);
    m_cnt = cnt;
    m_ovf = ovf;
    exp_lat = (ovf || cnt == 0) ? 1 : 2 * cnt + 1;
    seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 4 * cnt + 10; i++) begin
      @(negedge clk);
      lookup_req = 1'b0;
      if (done) begin
        seen = 1'b1;
        lat = cyc - (c0 + 1);
        break;
      end
    end
    check("done_seen", 32'(seen), 1);
    check("done_latency", 32'(lat), 32'(exp_lat));
    check("blob_count", 32'(blob_count), 32'(exp_blob));
    check("overflow", 32'(overflow), 32'(ovf));
    check("busy_after_done", 32'(busy), 0);
    check("ready_after_done", 32'(lookup_ready), 1);
    @(negedge clk);
    check("done_pulse_width", 32'(done), 0);
  endtask

  // Scoreboard monitor: every rvalid must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (lookup_rvalid) begin
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL lookup_spurious: rvalid=1 root=%0d at cycle %0d, expected no rvalid",
                 lookup_root, cyc);
      end else begin
        e = exp_q.pop_front();
        if (int'(lookup_root) != e.root || cyc != e.due) begin
          n_fail++;
          $display("FAIL lookup_root: got %0d at cycle %0d, expected %0d at cycle %0d",
                   lookup_root, cyc, e.root, e.due);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      n_assert++;
      n_fail++;
      e = exp_q.pop_front();
      $display("FAIL lookup_rvalid: got 0 at cycle %0d, expected 1 (root %0d)", cyc, e.root);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int chain_labs [6];
    bit seen_done;
    int cnt;
    chain_labs = '{0, 3, 4, 5, 1, 2};
    for (int i = 0; i < 2**INDEXW; i++) tbl[i] = '0;
    for (int i = 0; i < 256; i++) m_root[i] = 0;

    #2;
    check_reset("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Requests before any resolve are ignored.
    @(negedge clk);
    lookup_req   = 1'b1;
    lookup_label = LS'(1);
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(lookup_ready), 0);
    lookup_req = 1'b0;

    // Chain table.
    tbl[1] = LS'(1); tbl[2] = LS'(1); tbl[3] = LS'(2); tbl[4] = LS'(4);
    resolve(4, 1'b0, 1'b0, 0);
    check("chain_blobs", 32'(blob_count), 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue(chain_labs[i]);
    end
    @(negedge clk);
    lookup_req = 1'b0;

    // Overflow, with a lookup accepted on the frame-end cycle.
    resolve(3, 1'b1, 1'b1, 2);
    for (int l = 1; l <= 3; l++) begin
      @(negedge clk);
      issue(l);
    end
    @(negedge clk);
    lookup_req = 1'b0;
    too_many_labels = 1'b0;

    // Invalid parents.
    tbl[1] = LS'(0); tbl[2] = LS'(7);
    resolve(2, 1'b0, 1'b1, 4);
    check("invalid_parent_blobs", 32'(blob_count), 2);
    burst(4, 3);

    // Empty frame.
    resolve(0, 1'b0, 1'b1, 1);
    burst(2, 2);

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      cnt = int'($urandom_range(1, 24));
      load_random(cnt);
      resolve(cnt, ($urandom_range(0, 5) == 0), 1'b1, int'($urandom_range(0, m_cnt + 1)));
      too_many_labels = 1'b0;
      burst(8, cnt + 2);
    end

    // Abort in the 3rd READ of a 6-label walk.
    load_random(6);
    label_count = LS'(6);
    @(negedge clk);
    frame_valid = 1'b1;
    repeat (2) @(negedge clk);
    frame_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_pre_busy", 32'(busy), 1);
    check("abort_pre_index", 32'(ll_index), 3);
    frame_valid = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(lookup_ready), 0);
    seen_done = done;
    lookup_req   = 1'b1;
    lookup_label = LS'(1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen_done |= done;
    end
    lookup_req = 1'b0;
    check("abort_no_done", 32'(seen_done), 0);
    check("abort_ready_stays_low", 32'(lookup_ready), 0);

    // IDLE must respond to the next frame end.
    load_random(5);
    resolve(5, 1'b0, 1'b0, 0);
    burst(6, 7);

    // Asynchronous reset during WRITE.
    load_random(5);
    label_count = LS'(5);
    @(negedge clk);
    frame_valid = 1'b1;
    repeat (2) @(negedge clk);
    frame_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_pre_busy", 32'(busy), 1);
    #1 reset_n = 1'b0;
    #1 check_reset("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    load_random(7);
    resolve(7, 1'b0, 1'b0, 0);
    burst(6, 9);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
